// File: rtl/ym_bus_if.sv
// ============================================================================
// Module   : ym_bus_if
// Brief    : Z80-side host bus interface for a YM-style FM chip. Synchronises
//            the asynchronous bus strobes into PHI_S, latches per-bank register
//            addresses, issues one-cycle register write pulses toward the FM
//            stage, tracks the write-busy window and returns status reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ym_bus_if #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       PHI_S,
    input  logic       nRESET,
    input  logic       nCS,
    input  logic       nWR,
    input  logic       nRD,
    input  logic [1:0] A,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOUT_EN,
    input  logic [1:0] TFLAG,
    output logic       REG_WE,
    output logic       REG_BANK,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_DATA,
    output logic       BUSY
);

    // Bus bundle layout: {nCS, nWR, nRD, A[1:0], DIN[7:0]}; idle = strobes high.
    localparam logic [12:0] c_BUS_IDLE  = {3'b111, 2'b00, 8'h00};
    localparam logic [7:0]  c_BUSY_LOAD = 8'(BUSY_CYCLES - 1);

    logic [12:0] r_bus_meta;
    logic [12:0] r_bus_sync;
    logic        r_nwr_prev;

    logic [7:0]  r_addr_latch [0:1];
    logic [1:0]  r_addr_valid;

    logic        r_reg_we;
    logic        r_reg_bank;
    logic [7:0]  r_reg_addr;
    logic [7:0]  r_reg_data;
    logic        r_busy;
    logic [7:0]  r_busy_cnt;
    logic [7:0]  r_dout;
    logic        r_dout_en;

    logic        w_sync_ncs;
    logic        w_sync_nwr;
    logic        w_sync_nrd;
    logic [1:0]  w_sync_a;
    logic [7:0]  w_sync_din;
    logic        w_wr_event;
    logic        w_addr_wr;
    logic        w_data_wr;

    assign w_sync_ncs = r_bus_sync[12];
    assign w_sync_nwr = r_bus_sync[11];
    assign w_sync_nrd = r_bus_sync[10];
    assign w_sync_a   = r_bus_sync[9:8];
    assign w_sync_din = r_bus_sync[7:0];

    // A write is the falling edge of the synchronised nWR while chip-selected;
    // holding nWR low therefore produces only one event.
    assign w_wr_event = !w_sync_nwr && r_nwr_prev && !w_sync_ncs;
    assign w_addr_wr  = w_wr_event && !w_sync_a[0];
    assign w_data_wr  = w_wr_event && w_sync_a[0] && !r_busy && r_addr_valid[w_sync_a[1]];

    // Two-flop synchroniser for all bus inputs plus previous-cycle nWR for edge detect.
    always_ff @(posedge PHI_S or negedge nRESET) begin
        if (!nRESET) begin
            r_bus_meta <= c_BUS_IDLE;
            r_bus_sync <= c_BUS_IDLE;
            r_nwr_prev <= 1'b1;
        end else begin
            r_bus_meta <= {nCS, nWR, nRD, A, DIN};
            r_bus_sync <= r_bus_meta;
            r_nwr_prev <= w_sync_nwr;
        end
    end

    // Per-bank address latch; address writes are taken even while busy.
    always_ff @(posedge PHI_S or negedge nRESET) begin
        if (!nRESET) begin
            r_addr_latch[0] <= 8'h00;
            r_addr_latch[1] <= 8'h00;
            r_addr_valid    <= 2'b00;
        end else if (w_addr_wr) begin
            r_addr_latch[w_sync_a[1]] <= w_sync_din;
            r_addr_valid[w_sync_a[1]] <= 1'b1;
        end
    end

    // Accepted data write: one-cycle strobe, bank/addr/data held until the next one.
    always_ff @(posedge PHI_S or negedge nRESET) begin
        if (!nRESET) begin
            r_reg_we   <= 1'b0;
            r_reg_bank <= 1'b0;
            r_reg_addr <= 8'h00;
            r_reg_data <= 8'h00;
        end else begin
            r_reg_we <= w_data_wr;
            if (w_data_wr) begin
                r_reg_bank <= w_sync_a[1];
                r_reg_addr <= r_addr_latch[w_sync_a[1]];
                r_reg_data <= w_sync_din;
            end
        end
    end

    // Busy window: set with the strobe, released when the down-counter expires at zero.
    always_ff @(posedge PHI_S or negedge nRESET) begin
        if (!nRESET) begin
            r_busy     <= 1'b0;
            r_busy_cnt <= 8'h00;
        end else if (w_data_wr) begin
            r_busy     <= 1'b1;
            r_busy_cnt <= c_BUSY_LOAD;
        end else if (r_busy) begin
            if (r_busy_cnt == 8'h00) begin
                r_busy <= 1'b0;
            end else begin
                r_busy_cnt <= r_busy_cnt - 8'd1;
            end
        end
    end

    // Status read path: status byte on the address port, zero on the data port.
    always_ff @(posedge PHI_S or negedge nRESET) begin
        if (!nRESET) begin
            r_dout    <= 8'h00;
            r_dout_en <= 1'b0;
        end else begin
            r_dout    <= w_sync_a[0] ? 8'h00 : {r_busy, 5'b00000, TFLAG};
            r_dout_en <= !w_sync_ncs && !w_sync_nrd;
        end
    end

    assign DOUT     = r_dout;
    assign DOUT_EN  = r_dout_en;
    assign REG_WE   = r_reg_we;
    assign REG_BANK = r_reg_bank;
    assign REG_ADDR = r_reg_addr;
    assign REG_DATA = r_reg_data;
    assign BUSY     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ym_bus_if.sv
// ============================================================================
// Module   : tb_ym_bus_if
// Brief    : Self-checking bench for ym_bus_if. A transaction-level model
//            tracks the sampled bus history, the address latches and the
//            remaining busy time; directed scenarios are followed by random
//            bus traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ym_bus_if;

    localparam int BUSY_CYCLES = 32;

    typedef struct packed {
        logic       ncs;
        logic       nwr;
        logic       nrd;
        logic [1:0] a;
        logic [7:0] din;
    } bus_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ncs, nwr, nrd;
    logic [1:0] a;
    logic [7:0] din;
    logic [1:0] tflag;
    logic [7:0] dout;
    logic       dout_en;
    logic       reg_we;
    logic       reg_bank;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bus_t       h1, h2, h3;
    logic [7:0] m_latch [0:1];
    bit         m_valid [0:1];
    int         m_rem;
    logic       m_we, m_bank, m_den;
    logic [7:0] m_addr, m_data, m_dout;
    int         we_seen;
    bit         rnd_tf;

    always #5 clk = ~clk;

    ym_bus_if #(.BUSY_CYCLES(BUSY_CYCLES)) u_dut (
        .PHI_S    (clk),
        .nRESET   (rst_n),
        .nCS      (ncs),
        .nWR      (nwr),
        .nRD      (nrd),
        .A        (a),
        .DIN      (din),
        .DOUT     (dout),
        .DOUT_EN  (dout_en),
        .TFLAG    (tflag),
        .REG_WE   (reg_we),
        .REG_BANK (reg_bank),
        .REG_ADDR (reg_addr),
        .REG_DATA (reg_data),
        .BUSY     (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bus_t idle_bus();
        bus_t b;
        b.ncs = 1'b1; b.nwr = 1'b1; b.nrd = 1'b1; b.a = 2'b00; b.din = 8'h00;
        return b;
    endfunction

    task automatic model_reset();
        h1 = idle_bus(); h2 = idle_bus(); h3 = idle_bus();
        m_latch[0] = 8'h00; m_latch[1] = 8'h00;
        m_valid[0] = 1'b0;  m_valid[1] = 1'b0;
        m_rem = 0;
        m_we = 1'b0; m_bank = 1'b0; m_addr = 8'h00; m_data = 8'h00;
        m_dout = 8'h00; m_den = 1'b0;
    endtask

    // One PHI_S edge of the model: decisions use the bus as sampled two edges
    // earlier, the write edge compares it against the sample three edges earlier.
    task automatic model_edge(input bus_t cur, input logic [1:0] tf);
        bus_t e, p;
        bit   ev, was_busy;
        e = h2;
        p = h3;
        ev = !e.nwr && p.nwr && !e.ncs;
        was_busy = (m_rem > 0);
        m_we = 1'b0;
        if (ev && !e.a[0]) begin
            m_latch[e.a[1]] = e.din;
            m_valid[e.a[1]] = 1'b1;
        end
        if (ev && e.a[0] && !was_busy && m_valid[e.a[1]]) begin
            m_we   = 1'b1;
            m_bank = e.a[1];
            m_addr = m_latch[e.a[1]];
            m_data = e.din;
            m_rem  = BUSY_CYCLES;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        m_dout = e.a[0] ? 8'h00 : {was_busy, 5'b00000, tf};
        m_den  = !e.ncs && !e.nrd;
        h3 = h2; h2 = h1; h1 = cur;
    endtask

    task automatic compare_all();
        check_val("reg_we",   reg_we,   m_we);
        check_val("busy",     busy,     (m_rem > 0));
        check_val("dout",     dout,     m_dout);
        check_val("dout_en",  dout_en,  m_den);
        check_val("reg_bank", reg_bank, m_bank);
        check_val("reg_addr", reg_addr, m_addr);
        check_val("reg_data", reg_data, m_data);
    endtask

    task automatic cycle();
        bus_t cur;
        @(posedge clk);
        cur = {ncs, nwr, nrd, a, din};
        model_edge(cur, tflag);
        #1;
        compare_all();
        if (reg_we) we_seen++;
        if (rnd_tf) tflag = 2'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_write(input logic [1:0] ad, input logic [7:0] d, input int hold, input int gap);
        ncs = 1'b0; a = ad; din = d; nwr = 1'b0;
        repeat (hold) cycle();
        nwr = 1'b1; ncs = 1'b1;
        repeat (gap) cycle();
    endtask

    task automatic bus_read(input logic [1:0] ad, input int hold, input int gap);
        ncs = 1'b0; a = ad; nrd = 1'b0;
        repeat (hold) cycle();
        nrd = 1'b1; ncs = 1'b1;
        repeat (gap) cycle();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_busy",   busy,   1'b0);
        check_val("rst_reg_we", reg_we, 1'b0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w0, bc, op;
        rst_n = 1'b0; ncs = 1'b1; nwr = 1'b1; nrd = 1'b1;
        a = 2'b00; din = 8'h00; tflag = 2'b00;
        rnd_tf = 1'b0; we_seen = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        idle(2);

        // Address then data write, strobe latency and busy length
        bus_write(2'd0, 8'h28, 1, 3);
        ncs = 1'b0; a = 2'd1; din = 8'hF1; nwr = 1'b0;
        cycle();
        cycle();
        check_val("we_before_3rd", reg_we, 1'b0);
        cycle();
        check_val("we_3rd_edge", reg_we, 1'b1);
        check_val("we_addr_28", reg_addr, 8'h28);
        check_val("we_data_f1", reg_data, 8'hF1);
        nwr = 1'b1; ncs = 1'b1;
        bc = busy ? 1 : 0;
        repeat (40) begin
            cycle();
            if (busy) bc++;
        end
        check_val("busy_len", bc, BUSY_CYCLES);

        // Data write during busy is dropped, later one reuses the address
        w0 = we_seen;
        bus_write(2'd1, 8'h55, 1, 9);
        bus_write(2'd1, 8'h66, 1, 30);
        check_val("drop_in_busy", we_seen - w0, 1);
        bus_write(2'd1, 8'h77, 1, 5);
        check_val("after_busy_cnt", we_seen - w0, 2);
        check_val("reuse_addr", reg_addr, 8'h28);
        check_val("reuse_data", reg_data, 8'h77);
        idle(35);

        // Bank 1 address/data, bank 0 latch untouched
        bus_write(2'd2, 8'h30, 1, 2);
        bus_write(2'd3, 8'h7F, 1, 5);
        check_val("bank1_bank", reg_bank, 1'b1);
        check_val("bank1_addr", reg_addr, 8'h30);
        check_val("bank1_data", reg_data, 8'h7F);
        idle(35);
        bus_write(2'd1, 8'h11, 1, 5);
        check_val("bank0_kept", reg_addr, 8'h28);

        // Status read during and after busy
        tflag = 2'b10;
        ncs = 1'b0; a = 2'd0; nrd = 1'b0;
        cycle();
        cycle();
        check_val("den_early", dout_en, 1'b0);
        cycle();
        check_val("den_3rd", dout_en, 1'b1);
        check_val("dout_busy", dout, 8'h82);
        nrd = 1'b1; ncs = 1'b1;
        idle(40);
        bus_read(2'd0, 3, 0);
        check_val("dout_idle", dout, 8'h02);
        idle(3);

        // Reset mid-busy aborts busy and forgets the address
        bus_write(2'd0, 8'h28, 1, 3);
        bus_write(2'd1, 8'h21, 1, 4);
        do_reset();
        w0 = we_seen;
        bus_write(2'd1, 8'h22, 1, 10);
        check_val("no_addr_drop", we_seen - w0, 0);

        // Long nWR low counts as a single write
        bus_write(2'd0, 8'h40, 1, 3);
        w0 = we_seen;
        bus_write(2'd1, 8'h99, 50, 40);
        check_val("long_wr_once", we_seen - w0, 1);

        // Random traffic against the model
        rnd_tf = 1'b1;
        repeat (80) begin
            op = $urandom_range(0, 9);
            if (op <= 2) begin
                bus_write({1'($urandom), 1'b0}, 8'($urandom), $urandom_range(1, 3), $urandom_range(0, 6));
            end else if (op <= 5) begin
                bus_write({1'($urandom), 1'b1}, 8'($urandom), $urandom_range(1, 4), $urandom_range(0, 40));
            end else if (op <= 7) begin
                bus_read(2'($urandom), $urandom_range(1, 5), $urandom_range(0, 5));
            end else if (op == 8) begin
                ncs = 1'b0; nrd = 1'b0; nwr = 1'b0; a = 2'($urandom); din = 8'($urandom);
                repeat ($urandom_range(1, 4)) cycle();
                ncs = 1'b1; nrd = 1'b1; nwr = 1'b1;
                idle($urandom_range(0, 10));
            end else begin
                if ($urandom_range(0, 3) == 0) do_reset();
                idle($urandom_range(1, 8));
            end
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ym_bus_if.md
YM_BUS_IF -- requirements
Module: ym_bus_if

Parameters
REQ-001 SHALL provide parameter BUSY_CYCLES, default 32, the number of PHI_S cycles BUSY stays high after an accepted data write (legal range 1..255).

Interface
REQ-002 SHALL have port PHI_S, input, 1, sole clock, all state on rising edge.
REQ-003 SHALL have port nRESET, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port nCS, input, 1, chip select from the Z80 bus, asynchronous, active-low.
REQ-005 SHALL have port nWR, input, 1, write strobe, asynchronous, active-low.
REQ-006 SHALL have port nRD, input, 1, read strobe, asynchronous, active-low.
REQ-007 SHALL have port A, input, 2, bus address: A[0]=0 address/status, A[0]=1 data; A[1] selects register bank.
REQ-008 SHALL have port DIN, input, 8, bus write data.
REQ-009 SHALL have port DOUT, output, 8, registered status read data.
REQ-010 SHALL have port DOUT_EN, output, 1, high while a synchronised read is active.
REQ-011 SHALL have port TFLAG, input, 2, timer B/A flags, already synchronous to PHI_S.
REQ-012 SHALL have port REG_WE, output, 1, one-cycle register write pulse toward the FM stage.
REQ-013 SHALL have port REG_BANK, output, 1, bank of the write.
REQ-014 SHALL have port REG_ADDR, output, 8, register address of the write.
REQ-015 SHALL have port REG_DATA, output, 8, register data of the write.
REQ-016 SHALL have port BUSY, output, 1, write-busy flag.

Function
REQ-017 SHALL pass nCS, nWR, nRD, A, DIN through two PHI_S flop stages before any use; the second stage is "sync".
REQ-018 SHALL detect a write event when sync nWR is 0, its previous-cycle value is 1, and sync nCS is 0 in the same cycle.
REQ-019 SHALL, on a write event with sync A[0]=0, latch sync DIN into ADDR_LATCH[sync A[1]] and set ADDR_VALID[sync A[1]], irrespective of BUSY.
REQ-020 SHALL, on a write event with sync A[0]=1, BUSY=0 and ADDR_VALID[sync A[1]]=1, accept a data write, pulsing REG_WE for exactly one cycle with REG_BANK=sync A[1], REG_ADDR=ADDR_LATCH[bank], REG_DATA=sync DIN.
REQ-021 SHALL hold REG_BANK/REG_ADDR/REG_DATA stable until the next accepted data write.
REQ-022 SHALL drop, with no REG_WE, a data write occurring while BUSY=1 or while ADDR_VALID for that bank is 0.
REQ-023 SHALL keep ADDR_LATCH and ADDR_VALID unchanged after a data write, so consecutive data writes reuse the address.
REQ-024 SHALL assert REG_WE on the third PHI_S rising edge after nWR falls, counting the first sampling edge as edge 1.
REQ-025 SHALL set BUSY on the same edge REG_WE rises, load an 8-bit down-counter with BUSY_CYCLES-1, and clear BUSY on the edge the counter is 0 and decrements, giving exactly BUSY_CYCLES high cycles.
REQ-026 SHALL treat nWR held low across many cycles as a single write event.
REQ-027 SHALL drive DOUT_EN = sync nCS=0 and sync nRD=0, registered.
REQ-028 SHALL register DOUT every cycle as {BUSY, 5'b00000, TFLAG[1:0]} when sync A[0]=0, and 8'h00 when sync A[0]=1.
REQ-029 SHALL ignore simultaneous sync nRD and nWR low for read purposes; the write is still processed.

Reset
REQ-030 SHALL on nRESET low asynchronously clear all sync stages to idle (nCS, nWR, nRD=1; A, DIN=0), ADDR_LATCH=0, ADDR_VALID=0, REG_WE=0, REG_BANK=0, REG_ADDR=0, REG_DATA=0, BUSY=0, counter=0, DOUT=0, DOUT_EN=0.
REQ-031 SHALL abort an in-progress busy period on reset; after release the first data write without a prior address write is dropped.

Verification
REQ-032 Addr write A=0, DIN=0x28, then data write A=1, DIN=0xF1 -> single REG_WE with BANK=0, ADDR=0x28, DATA=0xF1 on the 3rd edge after nWR falls; BUSY high exactly 32 cycles.
REQ-033 Second data write 10 cycles after first accepted one -> no REG_WE; data write after BUSY falls -> REG_WE with ADDR still 0x28.
REQ-034 Addr write bank 1 (A=2, DIN=0x30) then data (A=3, DIN=0x7F) -> REG_BANK=1, ADDR=0x30, DATA=0x7F; bank 0 latch unchanged.
REQ-035 Read A=0 with TFLAG=2'b10 during busy -> DOUT=0x82, DOUT_EN high 3 edges after nRD falls; after busy -> DOUT=0x02.
REQ-036 nRESET pulsed mid-busy -> BUSY=0 immediately; subsequent data write without address write -> no REG_WE.
REQ-037 nWR held low 50 cycles with nCS low, A=1 -> exactly one REG_WE pulse.
